// File: rtl/rv_run_monitor.sv
// Run-control and OUT-bus monitor for the rvmyth core: holds the core in reset, logs every
// OUT change with a cycle timestamp into a show-ahead FIFO, and latches PASS/FAIL once OUT settles.
module rv_run_monitor #(
    parameter int OUT_W        = 10,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int RESET_CYCLES = 60,
    parameter int TIMEOUT      = 500,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [OUT_W-1:0]       cpu_out,
    input  logic [OUT_W-1:0]       expected,
    output logic                   cpu_reset,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [TS_W+OUT_W-1:0]  rd_data,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   overflow,
    output logic                   done,
    output logic                   pass,
    output logic                   fail
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int DATA_W = TS_W + OUT_W;

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [TS_W-1:0]     ts_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [OUT_W-1:0]    prev_q;
    logic                cpu_reset_q, done_q, pass_q, fail_q, overflow_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic event_w, full_w, empty_w, pop_w, push_w, drop_w;

    assign event_w = (state_q == RUN) && (cpu_out != prev_q);
    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);
    assign pop_w   = rd_en && !empty_w;
    assign push_w  = event_w && (!full_w || pop_w);
    assign drop_w  = event_w && full_w && !pop_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_w) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_w)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push_w && !pop_w)      count_d = count_q + 1'b1;
        else if (pop_w && !push_w) count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (push_w) mem_q[wr_ptr_q] <= {ts_q, cpu_out};
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            ts_q        <= '0;
            idle_q      <= '0;
            prev_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            prev_q   <= cpu_out;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (drop_w) overflow_q <= 1'b1;
            case (state_q)
                HOLD: begin
                    if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                        state_q     <= RUN;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RUN: begin
                    if (ts_q != '1) ts_q <= ts_q + 1'b1;
                    // The event cycle itself is the first stable cycle of the new value.
                    if (event_w) begin
                        idle_q <= IDLE_W'(1);
                    end else if (idle_q >= IDLE_W'(TIMEOUT - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (cpu_out == expected);
                        fail_q  <= (cpu_out != expected);
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign rd_valid   = !empty_w;
    assign rd_data    = empty_w ? '0 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
endmodule
